// File: rtl/wasm_program_loader_pkg.sv
// ---------------------------------------------------------------------------
// wasm_program_loader_pkg
//   Shared definitions for the WASM program loader: FSM state encodings,
//   load error codes, frame start byte and default geometry.
// ---------------------------------------------------------------------------
package wasm_program_loader_pkg;

    // Default instruction BRAM address width (one byte per address).
    localparam int         LDR_ADDR_W_DEF  = 8;
    // Default maximum idle cycles between bytes inside a frame.
    localparam int         LDR_TIMEOUT_DEF = 1024;
    // Frame start byte.
    localparam logic [7:0] LDR_MAGIC       = 8'hA5;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_LO = 3'd1,
        LDR_LEN_HI = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_CSUM   = 3'd4,
        LDR_RUN    = 3'd5,
        LDR_ERR    = 3'd6
    } ldr_state_e;

    typedef enum logic [1:0] {
        LDR_ERR_NONE = 2'd0,
        LDR_ERR_LEN  = 2'd1,
        LDR_ERR_CSUM = 2'd2,
        LDR_ERR_TMO  = 2'd3
    } ldr_err_e;

    // True in the states that sit inside a frame (after MAGIC, before RUN).
    function automatic logic ldr_in_frame(input ldr_state_e s);
        return (s == LDR_LEN_LO) || (s == LDR_LEN_HI) ||
               (s == LDR_DATA)   || (s == LDR_CSUM);
    endfunction

endpackage

// File: rtl/wasm_loader_timeout.sv
// ---------------------------------------------------------------------------
// wasm_loader_timeout
//   Inter-byte idle counter. Cleared by load_i or whenever disabled; counts
//   enabled idle cycles and flags expiry on the TIMEOUT_CYC-th of them.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   load_i   a byte was accepted this cycle (restart the count)
//   en_i     counting window is open (inside a frame)
//   expire_o this cycle is the TIMEOUT_CYC-th idle cycle in a row
// ---------------------------------------------------------------------------
module wasm_loader_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // cnt_q holds the number of idle cycles already elapsed, so expiry is
    // flagged on the cycle that would make it TIMEOUT_CYC.
    assign expire_o = en_i && !load_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/wasm_program_loader.sv
// ---------------------------------------------------------------------------
// wasm_program_loader
//   Receives a framed WebAssembly program (MAGIC, LEN_LO, LEN_HI, payload,
//   CSUM) over a byte valid/ready stream, writes the payload into the
//   instruction BRAM, then releases the core from reset and counts run
//   cycles until the core finishes or faults.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_byte_valid, i_byte    input byte stream
//   o_byte_ready            loader accepts a byte this cycle
//   o_mem_we/addr/wdata     BRAM write port (registered, one pulse per byte)
//   o_core_rst_n            active-low core reset, high only in RUN
//   i_instr_finish          core finished
//   i_core_fault            core fault (OR of core error flags)
//   i_clear                 leave ERR
//   o_load_error, o_err_code load error flag and cause
//   o_run_done, o_run_fault sticky run status
//   o_run_cycles            saturating RUN cycle count
// ---------------------------------------------------------------------------
module wasm_program_loader
    import wasm_program_loader_pkg::*;
#(
    parameter int         ADDR_W      = LDR_ADDR_W_DEF,
    parameter int         TIMEOUT_CYC = LDR_TIMEOUT_DEF,
    parameter logic [7:0] MAGIC       = LDR_MAGIC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_core_rst_n,
    input  logic              i_instr_finish,
    input  logic              i_core_fault,
    input  logic              i_clear,
    output logic              o_load_error,
    output logic [1:0]        o_err_code,
    output logic              o_run_done,
    output logic              o_run_fault,
    output logic [31:0]       o_run_cycles
);

    // Largest program that fits in the BRAM.
    localparam logic [16:0] LEN_MAX = 17'(1) << ADDR_W;

    ldr_state_e        state_q;
    ldr_err_e          err_q;
    logic [15:0]       len_q;
    logic [15:0]       idx_q;
    logic [7:0]        sum_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              run_done_q;
    logic              run_fault_q;
    logic [31:0]       run_cycles_q;

    logic        ready;
    logic        accept;
    logic        tmo_expire;
    logic [15:0] len_full;
    logic        last_byte;

    assign ready     = (state_q == LDR_IDLE) || ldr_in_frame(state_q);
    assign accept    = i_byte_valid && ready && !i_rst;
    assign len_full  = {i_byte, len_q[7:0]};
    assign last_byte = ({1'b0, idx_q} + 17'd1) == {1'b0, len_q};

    wasm_loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .load_i   (accept),
        .en_i     (ldr_in_frame(state_q)),
        .expire_o (tmo_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= LDR_IDLE;
            err_q        <= LDR_ERR_NONE;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            run_done_q   <= 1'b0;
            run_fault_q  <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            mem_we_q <= 1'b0;

            if (state_q == LDR_RUN && run_cycles_q != 32'hFFFF_FFFF) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end

            case (state_q)
                LDR_IDLE: begin
                    // Non-MAGIC bytes are accepted and dropped.
                    if (accept && i_byte == MAGIC) begin
                        state_q      <= LDR_LEN_LO;
                        run_done_q   <= 1'b0;
                        run_fault_q  <= 1'b0;
                        run_cycles_q <= '0;
                    end
                end
                LDR_LEN_LO: begin
                    if (accept) begin
                        len_q[7:0] <= i_byte;
                        state_q    <= LDR_LEN_HI;
                    end
                end
                LDR_LEN_HI: begin
                    if (accept) begin
                        len_q[15:8] <= i_byte;
                        idx_q       <= '0;
                        sum_q       <= '0;
                        if ({1'b0, len_full} > LEN_MAX) begin
                            state_q <= LDR_ERR;
                            err_q   <= LDR_ERR_LEN;
                        end else if (len_full == 16'd0) begin
                            state_q <= LDR_CSUM;
                        end else begin
                            state_q <= LDR_DATA;
                        end
                    end
                end
                LDR_DATA: begin
                    if (accept) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= idx_q[ADDR_W-1:0];
                        mem_wdata_q <= i_byte;
                        idx_q       <= idx_q + 16'd1;
                        sum_q       <= sum_q + i_byte;
                        if (last_byte) begin
                            state_q <= LDR_CSUM;
                        end
                    end
                end
                LDR_CSUM: begin
                    if (accept) begin
                        if (i_byte == sum_q) begin
                            state_q <= LDR_RUN;
                        end else begin
                            state_q <= LDR_ERR;
                            err_q   <= LDR_ERR_CSUM;
                        end
                    end
                end
                LDR_RUN: begin
                    // A fault wins over a simultaneous finish.
                    if (i_core_fault) begin
                        state_q     <= LDR_IDLE;
                        run_done_q  <= 1'b1;
                        run_fault_q <= 1'b1;
                    end else if (i_instr_finish) begin
                        state_q    <= LDR_IDLE;
                        run_done_q <= 1'b1;
                    end
                end
                LDR_ERR: begin
                    if (i_clear) begin
                        state_q <= LDR_IDLE;
                        err_q   <= LDR_ERR_NONE;
                    end
                end
                default: begin
                    state_q <= LDR_IDLE;
                end
            endcase

            // Expiry only fires on cycles with no accepted byte, so it never
            // competes with a frame transition above.
            if (tmo_expire) begin
                state_q <= LDR_ERR;
                err_q   <= LDR_ERR_TMO;
            end
        end
    end

    // Reset masks the handshake, the pending write and the core release in
    // the same cycle it is asserted.
    assign o_byte_ready = ready && !i_rst;
    assign o_mem_we     = mem_we_q && !i_rst;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wdata  = mem_wdata_q;
    assign o_core_rst_n = (state_q == LDR_RUN) && !i_rst;
    assign o_load_error = (state_q == LDR_ERR);
    assign o_err_code   = err_q;
    assign o_run_done   = run_done_q;
    assign o_run_fault  = run_fault_q;
    assign o_run_cycles = run_cycles_q;

endmodule

// File: tb/tb_wasm_program_loader.sv
module tb_wasm_program_loader;

    localparam int ADDR_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_byte_valid = 1'b0;
    logic [7:0]        i_byte = 8'h00;
    logic              o_byte_ready;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;
    logic              o_core_rst_n;
    logic              i_instr_finish = 1'b0;
    logic              i_core_fault = 1'b0;
    logic              i_clear = 1'b0;
    logic              o_load_error;
    logic [1:0]        o_err_code;
    logic              o_run_done;
    logic              o_run_fault;
    logic [31:0]       o_run_cycles;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [7:0]        wd[$];

    always #5 i_clk = ~i_clk;

    wasm_program_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(1024), .MAGIC(8'hA5)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_core_rst_n(o_core_rst_n), .i_instr_finish(i_instr_finish),
        .i_core_fault(i_core_fault), .i_clear(i_clear),
        .o_load_error(o_load_error), .o_err_code(o_err_code),
        .o_run_done(o_run_done), .o_run_fault(o_run_fault), .o_run_cycles(o_run_cycles)
    );

    // Write-port monitor
    always @(posedge i_clk) begin
        if (o_mem_we) begin
            wa.push_back(o_mem_addr);
            wd.push_back(o_mem_wdata);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge i_clk);
        i_byte_valid = 1'b1;
        i_byte = b;
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        cycles(2);
        checks++; if (o_byte_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_byte_ready); end
        checks++; if (o_core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core_rst_n got=%b exp=0", o_core_rst_n); end
        checks++; if ({o_mem_we, o_load_error, o_err_code, o_run_done, o_run_fault} !== 6'b0)
            begin failures++; $display("FAIL reset_flags got=%b exp=000000", {o_mem_we, o_load_error, o_err_code, o_run_done, o_run_fault}); end
        checks++; if (o_run_cycles !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", o_run_cycles); end
        @(negedge i_clk); i_rst = 1'b0;
        #1;
        checks++; if (o_byte_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", o_byte_ready); end
    endtask

    task automatic test_frame;
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h03); send(8'h00);
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h21);
        checks++; if (wa.size() != 3) begin failures++; $display("FAIL frame_nwrites got=%0d exp=3", wa.size()); end
        else begin
            checks++; if (wa[0] !== 8'd0 || wd[0] !== 8'h0A) begin failures++; $display("FAIL frame_w0 got=%h/%h exp=00/0a", wa[0], wd[0]); end
            checks++; if (wa[1] !== 8'd1 || wd[1] !== 8'h0B) begin failures++; $display("FAIL frame_w1 got=%h/%h exp=01/0b", wa[1], wd[1]); end
            checks++; if (wa[2] !== 8'd2 || wd[2] !== 8'h0C) begin failures++; $display("FAIL frame_w2 got=%h/%h exp=02/0c", wa[2], wd[2]); end
        end
        checks++; if (o_core_rst_n !== 1'b1 || o_byte_ready !== 1'b0)
            begin failures++; $display("FAIL frame_run_entry rst_n=%b ready=%b exp=1/0", o_core_rst_n, o_byte_ready); end
        cycles(49);
        checks++; if (o_run_cycles !== 32'd49 || o_run_done !== 1'b0)
            begin failures++; $display("FAIL frame_mid_run cycles=%0d done=%b exp=49/0", o_run_cycles, o_run_done); end
        i_instr_finish = 1'b1;
        cycles(1);
        i_instr_finish = 1'b0;
        checks++; if (o_run_done !== 1'b1 || o_run_fault !== 1'b0)
            begin failures++; $display("FAIL frame_done done=%b fault=%b exp=1/0", o_run_done, o_run_fault); end
        checks++; if (o_run_cycles !== 32'd50) begin failures++; $display("FAIL frame_cycles got=%0d exp=50", o_run_cycles); end
        checks++; if (o_core_rst_n !== 1'b0 || o_byte_ready !== 1'b1)
            begin failures++; $display("FAIL frame_idle rst_n=%b ready=%b exp=0/1", o_core_rst_n, o_byte_ready); end
    endtask

    task automatic test_csum_err;
        send(8'hA5);
        checks++; if (o_run_done !== 1'b0 || o_run_cycles !== 32'd0)
            begin failures++; $display("FAIL magic_clears done=%b cycles=%0d exp=0/0", o_run_done, o_run_cycles); end
        send(8'h03); send(8'h00);
        send(8'h0A); send(8'h0B); send(8'h0C); send(8'h22);
        checks++; if (o_load_error !== 1'b1 || o_err_code !== 2'd2)
            begin failures++; $display("FAIL csum_err err=%b code=%0d exp=1/2", o_load_error, o_err_code); end
        checks++; if (o_core_rst_n !== 1'b0 || o_byte_ready !== 1'b0)
            begin failures++; $display("FAIL csum_hold rst_n=%b ready=%b exp=0/0", o_core_rst_n, o_byte_ready); end
        cycles(3);
        checks++; if (o_load_error !== 1'b1) begin failures++; $display("FAIL csum_sticky err=%b exp=1", o_load_error); end
        @(negedge i_clk); i_clear = 1'b1;
        cycles(1);
        i_clear = 1'b0;
        checks++; if (o_load_error !== 1'b0 || o_err_code !== 2'd0 || o_byte_ready !== 1'b1)
            begin failures++; $display("FAIL csum_clear err=%b code=%0d ready=%b exp=0/0/1", o_load_error, o_err_code, o_byte_ready); end
    endtask

    task automatic test_drop_empty;
        wa.delete(); wd.delete();
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        checks++; if (wa.size() != 0) begin failures++; $display("FAIL empty_nwrites got=%0d exp=0", wa.size()); end
        checks++; if (o_core_rst_n !== 1'b1) begin failures++; $display("FAIL empty_run rst_n=%b exp=1", o_core_rst_n); end
        i_instr_finish = 1'b1;
        cycles(1);
        i_instr_finish = 1'b0;
        checks++; if (o_run_done !== 1'b1 || o_run_cycles !== 32'd1)
            begin failures++; $display("FAIL empty_done done=%b cycles=%0d exp=1/1", o_run_done, o_run_cycles); end
    endtask

    task automatic test_timeout;
        send(8'hA5); send(8'h05); send(8'h00);
        cycles(1023);
        checks++; if (o_load_error !== 1'b0) begin failures++; $display("FAIL tmo_early err=%b exp=0", o_load_error); end
        cycles(1);
        checks++; if (o_load_error !== 1'b1 || o_err_code !== 2'd3)
            begin failures++; $display("FAIL tmo_err err=%b code=%0d exp=1/3", o_load_error, o_err_code); end
        @(negedge i_clk); i_clear = 1'b1;
        cycles(1);
        i_clear = 1'b0;
    endtask

    task automatic test_len_overflow;
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h01); send(8'h01);
        checks++; if (o_load_error !== 1'b1 || o_err_code !== 2'd1)
            begin failures++; $display("FAIL len_err err=%b code=%0d exp=1/1", o_load_error, o_err_code); end
        cycles(2);
        checks++; if (wa.size() != 0) begin failures++; $display("FAIL len_nwrites got=%0d exp=0", wa.size()); end
        @(negedge i_clk); i_clear = 1'b1;
        cycles(1);
        i_clear = 1'b0;
    endtask

    // LEN == 2^ADDR_W is the largest legal frame; then finish+fault together.
    task automatic test_full_and_fault;
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h00); send(8'h01);
        checks++; if (o_load_error !== 1'b0) begin failures++; $display("FAIL full_len_ok err=%b exp=0", o_load_error); end
        for (int i = 0; i < 256; i++) send(8'(i));
        send(8'h80);
        checks++; if (wa.size() != 256) begin failures++; $display("FAIL full_nwrites got=%0d exp=256", wa.size()); end
        else begin
            checks++; if (wa[255] !== 8'hFF || wd[255] !== 8'hFF || wa[128] !== 8'h80 || wd[128] !== 8'h80)
                begin failures++; $display("FAIL full_last got=%h/%h exp=ff/ff", wa[255], wd[255]); end
        end
        checks++; if (o_core_rst_n !== 1'b1) begin failures++; $display("FAIL full_run rst_n=%b exp=1", o_core_rst_n); end
        i_instr_finish = 1'b1; i_core_fault = 1'b1;
        cycles(1);
        i_instr_finish = 1'b0; i_core_fault = 1'b0;
        checks++; if (o_run_fault !== 1'b1 || o_run_done !== 1'b1 || o_core_rst_n !== 1'b0)
            begin failures++; $display("FAIL fault_prio fault=%b done=%b rst_n=%b exp=1/1/0", o_run_fault, o_run_done, o_core_rst_n); end
    endtask

    task automatic test_rst_mid_data;
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h04); send(8'h00);
        send(8'h0A); send(8'h0B);
        cycles(1);
        @(negedge i_clk);
        i_rst = 1'b1; i_byte_valid = 1'b1; i_byte = 8'h0C;
        #1;
        checks++; if (o_byte_ready !== 1'b0 || o_core_rst_n !== 1'b0)
            begin failures++; $display("FAIL rst_now ready=%b rst_n=%b exp=0/0", o_byte_ready, o_core_rst_n); end
        cycles(2);
        @(negedge i_clk);
        i_rst = 1'b0; i_byte_valid = 1'b0;
        send(8'h0D);   // IDLE must drop this
        cycles(2);
        checks++; if (wa.size() != 2) begin failures++; $display("FAIL rst_nwrites got=%0d exp=2", wa.size()); end
        checks++; if (o_byte_ready !== 1'b1 || o_load_error !== 1'b0 || o_core_rst_n !== 1'b0)
            begin failures++; $display("FAIL rst_idle ready=%b err=%b rst_n=%b exp=1/0/0", o_byte_ready, o_load_error, o_core_rst_n); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_csum_err();
        test_drop_empty();
        test_timeout();
        test_len_overflow();
        test_full_and_fault();
        test_rst_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wasm_program_loader.md
Name: wasm_program_loader

Overview:
- Upstream stage of WASM_TOP: receives a framed WebAssembly program as a byte stream (valid/ready) and writes it into the instruction BRAM through the BRAM write port.
- Holds the core in reset while loading, releases it when a valid frame completes, and counts run cycles until the core signals finish.
- Replaces testbench `$readmemh` preloading for silicon and FPGA bring-up.

Parameters:
- ADDR_W, `instr_log2_bram_depth, instruction BRAM address width; one byte per address.
- TIMEOUT_CYC, 1024, maximum idle cycles between bytes inside a frame before aborting.
- MAGIC, 8'hA5, frame start byte.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_byte_valid  in  1  input byte valid
- i_byte  in  8  input byte
- o_byte_ready  out  1  loader accepts a byte this cycle
- o_mem_we  out  1  BRAM write enable
- o_mem_addr  out  ADDR_W  BRAM write address
- o_mem_wdata  out  8  BRAM write data
- o_core_rst_n  out  1  active-low reset to WASM_TOP; low except in RUN
- i_instr_finish  in  1  core o_instr_finish
- i_core_fault  in  1  OR of core o_INSTR_ERROR, o_stack_exceed, o_stack_empty_pop
- i_clear  in  1  leave ERR state
- o_load_error  out  1  high while in ERR
- o_err_code  out  2  0 none, 1 length overflow, 2 checksum, 3 timeout
- o_run_done  out  1  sticky; set when RUN ends; cleared on next accepted MAGIC
- o_run_fault  out  1  sticky; RUN ended by i_core_fault; cleared with o_run_done
- o_run_cycles  out  32  cycles spent in RUN for the last/current program

Behaviour:
- Reset (sync, i_rst=1): state IDLE. All outputs 0, except o_byte_ready=1 after reset deasserts. o_core_rst_n=0.
- Handshake: a byte is accepted when i_byte_valid && o_byte_ready. o_byte_ready=1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM; 0 in RUN and ERR.
- Frame format: MAGIC, LEN_LO, LEN_HI, LEN payload bytes, CSUM. LEN is a 16-bit little-endian value. CSUM = sum of payload bytes mod 256.
- IDLE: an accepted MAGIC goes to LEN_LO and clears o_run_done, o_run_fault and o_run_cycles. Any other byte is accepted and dropped.
- LEN_LO -> LEN_HI: latch the low length byte.
- LEN_HI: latch the high length byte.
  - If LEN > 2^ADDR_W: go to ERR, code 1.
  - If LEN == 0: go to CSUM.
  - Otherwise go to DATA with index=0 and sum=0.
- DATA: each accepted byte is registered onto the write port with o_mem_we=1, o_mem_addr=index[ADDR_W-1:0], o_mem_wdata=byte, one cycle after acceptance. Then index+1 and sum+=byte (8-bit wrap). After byte LEN-1, go to CSUM.
- o_mem_we is a single-cycle pulse per byte; no writes occur outside DATA.
- CSUM: if the accepted byte == sum, go to RUN; otherwise go to ERR, code 2.
- Timeout: in LEN_LO..CSUM, a counter resets on each accepted byte. When it reaches TIMEOUT_CYC with no accepted byte, go to ERR, code 3. The counter is idle in other states.
- RUN: o_core_rst_n=1 from the first RUN cycle; o_run_cycles increments every RUN cycle.
  - i_instr_finish: go to IDLE and set o_run_done.
  - i_core_fault: go to IDLE and set o_run_done and o_run_fault.
  - Both in the same cycle: fault takes priority, so o_run_fault=1.
  - o_core_rst_n=0 from the cycle IDLE is entered.
- ERR: o_load_error=1, o_core_rst_n=0, input stalled. i_clear goes to IDLE and sets o_err_code=0. i_clear outside ERR is ignored.
- Partially written BRAM contents after ERR or reset are undefined; the core is never released with them.
- Reset mid-frame or mid-run: return immediately to IDLE with no further writes; o_core_rst_n=0 the same cycle.
- o_run_cycles saturates at 32'hFFFFFFFF.

Decomposition:
- Shared header wasm_defines.vh gains:
  - state encodings LDR_IDLE..LDR_ERR (3 bits);
  - error codes LDR_ERR_NONE/LEN/CSUM/TMO;
  - `LDR_MAGIC.
- One natural sub-module: wasm_loader_timeout (load/enable/expire counter), instantiated once.
- The FSM, write-port register and run counter stay in the top.

Test Plan:
- Frame A5 03 00 0A 0B 0C 21 -> three o_mem_we pulses:
  - addr0=0A, addr1=0B, addr2=0C;
  - then o_core_rst_n=1 and o_byte_ready=0.
  - Assert i_instr_finish after 50 RUN cycles -> o_run_done=1, o_run_cycles=50, o_core_rst_n=0, o_byte_ready=1.
- Same frame with CSUM 22 -> no release, o_load_error=1, o_err_code=2; i_clear -> IDLE, o_err_code=0.
- Bytes 00 FF then A5 00 00 00 -> leading bytes dropped, no writes, RUN entered (empty program).
- A5 05 00 then silence for 1024 cycles -> ERR, code 3; LEN = 2^ADDR_W+1 -> ERR, code 1, no writes.
- In RUN, raise i_instr_finish and i_core_fault in the same cycle -> o_run_fault=1, o_run_done=1.
- Separately, assert i_rst mid-DATA -> no further o_mem_we and state IDLE next cycle.
